ps2_host_tx: RTL and testbench

- PS/2 host-to-device transmitter: sends command bytes to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xEE echo.
- Counterpart of the keyboard receive path.
- Runs on the system clock. Drives the PS/2 clock and data lines open-collector: an enable pulls the line low, otherwise it is released.
- Sits between the command logic (valid/ready byte interface) and the board's PS/2 pads.

---
 rtl/ps2_pkg.sv | 30 +++
 rtl/ps2_host_tx_if.sv | 30 +++
 rtl/ps2_line_sync.sv | 30 +++
 rtl/ps2_host_tx.sv | 170 +++++++++++++++++
 tb/tb_ps2_host_tx.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM encoding, frame size, command bytes.
// Used by the host transmitter and the keyboard receive path.
package ps2_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE      = 3'd0;
  localparam state_t INHIBIT   = 3'd1;
  localparam state_t REQ       = 3'd2;
  localparam state_t SHIFT     = 3'd3;
  localparam state_t ACK       = 3'd4;
  localparam state_t WAIT_IDLE = 3'd5;
  localparam state_t DONE      = 3'd6;
  localparam state_t FAIL      = 3'd7;

  localparam int FRAME_BITS = 11;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ECHO     = 8'hEE;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] DEV_ACK      = 8'hFA;

  // Bits after the start bit: {stop, odd parity, data}, LSB first.
  function automatic logic [FRAME_BITS-2:0] tx_frame(
    input logic [7:0] d
  );
    return {1'b1, ~^d, d};
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command-side byte handshake and transfer status of the PS/2 host
// transmitter.
interface ps2_host_tx_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  busy,
    input  done,
    input  err
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output busy,
    output done,
    output err
  );

endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer and falling-edge detector for one PS/2 line.
// Flops idle high so reset never fakes an edge.
module ps2_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic pad,
  output logic level,
  output logic fall
);

  logic meta;
  logic cur;
  logic prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b1;
      cur  <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= pad;
      cur  <= meta;
      prev <= cur;
    end
  end

  assign level = cur;
  assign fall  = prev & ~cur;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send,
// then shifts one command frame out on device clock edges.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int START_TIMEOUT  = 750000,
  parameter int XFER_TIMEOUT   = 100000
) (
  input  logic         clk,
  input  logic         rst_n,
  ps2_host_tx_if.slave bus,
  input  logic         ps2_clk_in,
  input  logic         ps2_data_in,
  output logic         ps2_clk_oe,
  output logic         ps2_data_oe
);

  localparam int CMAX_A = (INHIBIT_CYCLES > START_TIMEOUT) ?
                          INHIBIT_CYCLES : START_TIMEOUT;
  localparam int CMAX   = (CMAX_A > XFER_TIMEOUT) ?
                          CMAX_A : XFER_TIMEOUT;
  localparam int CW     = $clog2(CMAX + 1);

  localparam logic [CW-1:0] INH_LAST   = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] INH_PRE    =
    CW'((INHIBIT_CYCLES > 1) ? INHIBIT_CYCLES - 2 : 0);
  localparam logic [CW-1:0] START_LAST = CW'(START_TIMEOUT - 1);
  localparam logic [CW-1:0] XFER_LAST  = CW'(XFER_TIMEOUT - 1);
  localparam logic [3:0]    LAST_SHIFT = 4'(FRAME_BITS - 2);

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [CW-1:0]           cnt_inc;
  logic [3:0]              bit_cnt;
  logic [FRAME_BITS-2:0]   shreg;
  logic                    clk_oe;
  logic                    data_oe;
  logic                    done_q;
  logic                    err_q;

  logic clk_lvl;
  logic clk_fall;
  logic data_lvl;
  logic unused_data_fall;

  logic in_xfer;
  logic tmo;
  logic nack;
  logic idle_ok;

  ps2_line_sync u_clk_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .pad   (ps2_clk_in),
    .level (clk_lvl),
    .fall  (clk_fall)
  );

  ps2_line_sync u_data_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .pad   (ps2_data_in),
    .level (data_lvl),
    .fall  (unused_data_fall)
  );

  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

  assign in_xfer = (state == SHIFT) || (state == ACK) ||
                   (state == WAIT_IDLE);

  // Timeout is checked ahead of any edge so it wins a tie.
  assign tmo  = ((state == REQ) && (cnt == START_LAST)) ||
                (in_xfer && (cnt == XFER_LAST));
  assign nack = (state == ACK) && clk_fall && data_lvl;

  assign idle_ok = (state == WAIT_IDLE) && clk_lvl && data_lvl;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      clk_oe  <= 1'b0;
      data_oe <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (tmo || nack) begin
        state   <= FAIL;
        clk_oe  <= 1'b0;
        data_oe <= 1'b0;
        done_q  <= 1'b1;
        err_q   <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.tx_valid) begin
              shreg   <= tx_frame(bus.tx_data);
              cnt     <= '0;
              clk_oe  <= 1'b1;
              data_oe <= (INHIBIT_CYCLES <= 1);
              state   <= INHIBIT;
            end
          end
          INHIBIT: begin
            cnt <= cnt_inc;
            // Start bit goes low one cycle before the clock release.
            if (cnt == INH_PRE) begin
              data_oe <= 1'b1;
            end
            if (cnt == INH_LAST) begin
              clk_oe  <= 1'b0;
              data_oe <= 1'b1;
              cnt     <= '0;
              state   <= REQ;
            end
          end
          REQ: begin
            cnt <= cnt_inc;
            if (clk_fall) begin
              data_oe <= ~shreg[0];
              bit_cnt <= 4'd1;
              cnt     <= '0;
              state   <= SHIFT;
            end
          end
          SHIFT: begin
            cnt <= cnt_inc;
            if (clk_fall) begin
              data_oe <= ~shreg[bit_cnt];
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == LAST_SHIFT) begin
                state <= ACK;
              end
            end
          end
          ACK: begin
            cnt <= cnt_inc;
            if (clk_fall) begin
              state <= WAIT_IDLE;
            end
          end
          WAIT_IDLE: begin
            cnt <= cnt_inc;
            if (idle_ok) begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
          DONE: state <= IDLE;
          FAIL: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign ps2_clk_oe   = clk_oe;
  assign ps2_data_oe  = data_oe;
  assign bus.tx_ready = (state == IDLE);
  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Randomized scoreboard bench for ps2_host_tx with an open-collector
// PS/2 device model clocking at a 40-cycle period.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH = 8;
  localparam int STO = 200;
  localparam int XTO = 2000;

  localparam int M_ACK    = 0;
  localparam int M_NOACK  = 1;
  localparam int M_SILENT = 2;
  localparam int M_ABORT  = 3;

  typedef struct packed {
    logic [10:0] frame;
    logic        err;
    logic        has_frame;
    logic        chk_to;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ps2_clk_oe;
  logic ps2_data_oe;
  logic ps2_clk_in;
  logic ps2_data_in;
  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rel_cyc = 0;
  int run = 0;
  logic last_data = 1'b0;

  exp_t        exp_q[$];
  logic [10:0] cap_q[$];

  ps2_host_tx_if bus();

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .START_TIMEOUT  (STO),
    .XFER_TIMEOUT   (XTO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference frame: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] ref_frame(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return {1'b1, (ones % 2 == 0), d, 1'b0};
  endfunction

  // Inhibit-phase monitor.
  always @(negedge clk) begin
    if (!rst_n) begin
      run = 0;
    end else if (ps2_clk_oe === 1'b1) begin
      run++;
      last_data = ps2_data_oe;
    end else if (run != 0) begin
      check("inhibit_len", run, INH);
      check("start_before_release", {31'd0, last_data}, 1);
      rel_cyc = cyc;
      run = 0;
    end
  end

  // Scoreboard monitor: every done pulse pops one expectation.
  always @(negedge clk) begin : mon_done
    exp_t e;
    if (rst_n && bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("err", {31'd0, bus.err}, {31'd0, e.err});
        check("lines_released", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
        if (e.has_frame) begin
          if (cap_q.size() == 0) check("capture_missing", 1, 0);
          else check("frame", {21'd0, cap_q.pop_front()},
                     {21'd0, e.frame});
        end
        if (e.chk_to) check("start_timeout_cycles", cyc - rel_cyc, STO);
      end
    end
  end

  task automatic device(input int mode, input int nfalls);
    logic [10:0] cap;
    int n;
    cap = '0;
    n = 0;
    while (ps2_clk_oe !== 1'b1 && n < 100) begin
      @(negedge clk); n++;
    end
    while (ps2_clk_oe !== 1'b0 && n < 100) begin
      @(negedge clk); n++;
    end
    if (n >= 100) begin
      check("release_seen", 0, 1);
      return;
    end
    if (mode == M_SILENT) return;
    cap[0] = ps2_data_in;
    repeat (30) @(negedge clk);
    for (int i = 1; i <= nfalls; i++) begin
      dev_clk_low = 1'b1;
      repeat (20) @(negedge clk);
      dev_clk_low = 1'b0;
      cap[i] = ps2_data_in;
      repeat (20) @(negedge clk);
    end
    if (mode == M_ABORT) return;
    cap_q.push_back(cap);
    if (mode == M_ACK) dev_data_low = 1'b1;
    repeat (10) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (20) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (5) @(negedge clk);
    dev_data_low = 1'b0;
  endtask

  task automatic wait_done(input bit post);
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < 3000) begin
      @(negedge clk); n++;
    end
    if (n >= 3000) begin
      check("done_timeout", 0, 1);
    end else if (post) begin
      @(negedge clk);
      check("done_one_cycle", {31'd0, bus.done}, 0);
      check("ready_after_done", {31'd0, bus.tx_ready}, 1);
    end
  endtask

  function automatic exp_t mk_exp(input logic [7:0] d, input int mode);
    exp_t e;
    e.frame     = ref_frame(d);
    e.err       = (mode != M_ACK);
    e.has_frame = (mode == M_ACK) || (mode == M_NOACK);
    e.chk_to    = (mode == M_SILENT);
    return e;
  endfunction

  task automatic send(input logic [7:0] d, input int mode);
    int n;
    n = 0;
    while (bus.tx_ready !== 1'b1 && n < 5000) begin
      @(negedge clk); n++;
    end
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'($urandom);
    if (mode == M_ABORT) begin
      device(mode, 5);
    end else begin
      exp_q.push_back(mk_exp(d, mode));
      fork
        device(mode, 10);
        wait_done(1'b1);
      join
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] r;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", {31'd0, bus.tx_ready}, 1);
    check("rst_busy", {31'd0, bus.busy}, 0);
    check("rst_clk_oe", {31'd0, ps2_clk_oe}, 0);
    check("rst_data_oe", {31'd0, ps2_data_oe}, 0);
    check("rst_done_err", {30'd0, bus.done, bus.err}, 0);

    // Device traffic while idle must not start anything.
    dev_clk_low = 1'b1;
    repeat (20) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_fall_busy", {31'd0, bus.busy}, 0);

    send(CMD_SET_LEDS, M_ACK);
    send(8'h01, M_ACK);
    send(8'h00, M_ACK);
    send(CMD_RESET, M_ACK);
    send(8'hA5, M_NOACK);
    send(8'h3C, M_SILENT);

    send(8'h96, M_ABORT);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_clk_oe", {31'd0, ps2_clk_oe}, 0);
    check("abort_data_oe", {31'd0, ps2_data_oe}, 0);
    check("abort_busy", {31'd0, bus.busy}, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send(CMD_ECHO, M_ACK);

    // tx_valid held across a transfer; data changes while busy.
    r = 8'($urandom);
    bus.tx_data  = 8'hFF;
    bus.tx_valid = 1'b1;
    exp_q.push_back(mk_exp(8'hFF, M_ACK));
    exp_q.push_back(mk_exp(r, M_ACK));
    @(negedge clk);
    check("held_ready_busy", {31'd0, bus.tx_ready}, 0);
    bus.tx_data = r;
    fork
      device(M_ACK, 10);
      wait_done(1'b0);
    join
    check("held_ready_at_done", {31'd0, bus.tx_ready}, 0);
    @(negedge clk);
    check("held_ready_after_done", {31'd0, bus.tx_ready}, 1);
    @(negedge clk);
    check("held_second_accept", {31'd0, bus.busy}, 1);
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'($urandom);
    fork
      device(M_ACK, 10);
      wait_done(1'b1);
    join

    repeat (6) send(8'($urandom), M_ACK);

    repeat (20) @(negedge clk);
    check("pending_expected", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
